// File: rtl/pipeline_hazard_controller.sv
// Purpose : stall/flush sequencer for the 5-stage pipeline (PC enable, latch enables/flushes, halt, perf counters).
// Latency : enables/flushes are combinational from state and inputs; halt is registered, rising 2 edges after memory_halt.
// Backpressure: a dmem wait freezes every latch; a load-use hazard or a fetch miss holds the front end and inserts a bubble.
// Ports   : CLK/nRST clock and async active-low reset; ihit/dhit memory handshakes; decode_*/execute_*/memory_* hazard
//           sources; pc_en, *_en, *_flush pipeline control; halt status; stall_cycles/flush_events saturating counters.
module pipeline_hazard_controller #(
   parameter int CNT_W          = 32,
   parameter bit MEM_LOAD_CHECK = 1'b1
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic [4:0]       decode_rs,
   input  logic [4:0]       decode_rt,
   input  logic             decode_uses_rt,
   input  logic             execute_mem_to_reg,
   input  logic [4:0]       execute_reg_wr_addr,
   input  logic             memory_mem_to_reg,
   input  logic [4:0]       memory_reg_wr_addr,
   input  logic             memory_dmem_req,
   input  logic             memory_redirect,
   input  logic             memory_halt,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             halt,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic             halt_q, halt_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;

   logic lu_ex, lu_mem, lu;
   logic stall_inc, flush_inc;
   logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
   logic ifid_flush_c, idex_flush_c, exmem_flush_c;

   // $0 is hardwired zero, so a load targeting it can never create a dependency.
   assign lu_ex = execute_mem_to_reg && (execute_reg_wr_addr != 5'd0) &&
                  ((execute_reg_wr_addr == decode_rs) ||
                   (decode_uses_rt && (execute_reg_wr_addr == decode_rt)));
   // MEM-stage load data is not forwarded, so the consumer must wait one more cycle.
   assign lu_mem = MEM_LOAD_CHECK && memory_mem_to_reg && (memory_reg_wr_addr != 5'd0) &&
                   ((memory_reg_wr_addr == decode_rs) ||
                    (decode_uses_rt && (memory_reg_wr_addr == decode_rt)));
   assign lu = lu_ex || lu_mem;

   always_comb begin
      state_d       = state_q;
      stall_inc     = 1'b0;
      flush_inc     = 1'b0;
      pc_en_c       = 1'b0;
      ifid_en_c     = 1'b0;
      idex_en_c     = 1'b0;
      exmem_en_c    = 1'b0;
      memwb_en_c    = 1'b0;
      ifid_flush_c  = 1'b0;
      idex_flush_c  = 1'b0;
      exmem_flush_c = 1'b0;
      case (state_q)
         RUN: begin
            if (memory_halt) begin
               // Kill everything younger than HALT, let the older WB instruction retire.
               ifid_en_c     = 1'b1;
               idex_en_c     = 1'b1;
               exmem_en_c    = 1'b1;
               memwb_en_c    = 1'b1;
               ifid_flush_c  = 1'b1;
               idex_flush_c  = 1'b1;
               exmem_flush_c = 1'b1;
               state_d       = DRAIN;
            end else if (memory_dmem_req && !dhit) begin
               // Full freeze; a pending redirect stays in the frozen MEM latch until dhit.
               stall_inc = 1'b1;
            end else if (memory_redirect) begin
               pc_en_c       = 1'b1;
               ifid_en_c     = 1'b1;
               idex_en_c     = 1'b1;
               exmem_en_c    = 1'b1;
               memwb_en_c    = 1'b1;
               ifid_flush_c  = 1'b1;
               idex_flush_c  = 1'b1;
               exmem_flush_c = 1'b1;
               flush_inc     = 1'b1;
            end else if (lu) begin
               idex_en_c    = 1'b1;
               idex_flush_c = 1'b1;
               exmem_en_c   = 1'b1;
               memwb_en_c   = 1'b1;
               stall_inc    = 1'b1;
            end else if (!ihit) begin
               ifid_en_c    = 1'b1;
               ifid_flush_c = 1'b1;
               idex_en_c    = 1'b1;
               exmem_en_c   = 1'b1;
               memwb_en_c   = 1'b1;
               stall_inc    = 1'b1;
            end else begin
               pc_en_c    = 1'b1;
               ifid_en_c  = 1'b1;
               idex_en_c  = 1'b1;
               exmem_en_c = 1'b1;
               memwb_en_c = 1'b1;
            end
         end
         DRAIN:   state_d = HALTED;
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase
   end

   assign halt_d  = (state_d == HALTED);
   assign stall_d = (stall_inc && (stall_q != CNT_MAX)) ? stall_q + CNT_ONE : stall_q;
   assign flush_d = (flush_inc && (flush_q != CNT_MAX)) ? flush_q + CNT_ONE : flush_q;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= RUN;
         halt_q  <= 1'b0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         halt_q  <= halt_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   // Controls are forced low while reset is asserted, not only after the state register clears.
   assign pc_en        = nRST & pc_en_c;
   assign ifid_en      = nRST & ifid_en_c;
   assign idex_en      = nRST & idex_en_c;
   assign exmem_en     = nRST & exmem_en_c;
   assign memwb_en     = nRST & memwb_en_c;
   assign ifid_flush   = nRST & ifid_flush_c;
   assign idex_flush   = nRST & idex_flush_c;
   assign exmem_flush  = nRST & exmem_flush_c;
   assign halt         = halt_q;
   assign stall_cycles = stall_q;
   assign flush_events = flush_q;

endmodule
